uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 2048, giving the max hwclk cycles from tx_dv to tx_done before abort.
REQ-002 The block SHALL have port hwclk, input, 1, the single 12 MHz clock; all logic SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port hwrst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have ports req0_valid, input, 1 and req1_valid, input, 1: requester has a byte.
REQ-005 The block SHALL have ports req0_byte, input, 8 and req1_byte, input, 8: the offered payload.
REQ-006 The block SHALL have ports req0_last, input, 1 and req1_last, input, 1: the offered byte ends the burst.
REQ-007 The block SHALL have ports req0_ready, output, 1 and req1_ready, output, 1: byte accepted this cycle when valid is also high.
REQ-008 The block SHALL have ports tx_dv, output, 1 and tx_byte, output, 8, which drive uart_tx i_Tx_DV and i_Tx_Byte.
REQ-009 The block SHALL have port tx_done, input, 1, the single-cycle completion pulse from uart_tx.
REQ-010 The block SHALL have port grant, output, 2, a one-hot owner of the transmitter (00 = none).
REQ-011 The block SHALL have ports busy, output, 1 (state not IDLE) and timeout_err, output, 1 (single-cycle abort pulse).

Function
REQ-012 The FSM SHALL have exactly the states IDLE, ACCEPT, FIRE, WAIT_DONE.
REQ-013 In IDLE with no owner and any valid high, the block SHALL select an owner by round-robin, set grant, and go to ACCEPT on the next cycle.
REQ-014 Round-robin: after reset req0 SHALL have priority; after a burst from requester k completes or aborts, the other requester SHALL have priority.
REQ-015 In ACCEPT, ready SHALL be high only for the grant owner; when valid and ready are both high, the block SHALL capture byte and last into holding registers and go to FIRE.
REQ-016 In ACCEPT with owner valid low, the block SHALL wait indefinitely, keep grant, and deassert ready for the non-owner.
REQ-017 In FIRE, tx_dv SHALL be high for exactly one cycle, with tx_byte equal to the captured byte, and the FSM SHALL then go to WAIT_DONE.
REQ-018 tx_byte SHALL stay stable from FIRE until tx_done is sampled.
REQ-019 In WAIT_DONE, when tx_done is seen and captured last = 0, the block SHALL return to ACCEPT with the same owner (burst lock).
REQ-020 In WAIT_DONE, when tx_done is seen and captured last = 1, the block SHALL clear grant, update priority, and go to IDLE.
REQ-021 Latency: handshake in cycle N gives tx_dv in cycle N+1; tx_done in cycle M lets ready reassert no earlier than cycle M+1.
REQ-022 A watchdog counter SHALL count cycles in WAIT_DONE and saturate at TIMEOUT; on reaching TIMEOUT, the block SHALL pulse timeout_err for 1 cycle, clear grant, update priority, and go to IDLE.
REQ-023 tx_done outside WAIT_DONE SHALL be ignored.
REQ-024 At most one ready SHALL be high in any cycle, and ready SHALL never be high outside ACCEPT.
REQ-025 If both valids rise in the same IDLE cycle, the priority holder SHALL win; the loser SHALL see ready low until the winner's last byte completes.

Reset
REQ-026 While hwrst_n is low, the block SHALL force state IDLE, grant = 00, both readys = 0, tx_dv = 0, tx_byte = 8'h00, busy = 0, timeout_err = 0, watchdog = 0, and priority = req0.
REQ-027 Reset asserted mid-transfer SHALL take effect immediately (asynchronous); the pending byte SHALL be discarded and no tx_dv SHALL follow deassertion.
REQ-028 Reset deassertion SHALL be synchronised internally so that the first state change occurs no earlier than the second rising edge of hwclk after release.

Verification
REQ-029 Single byte: req0 sends 8'h41 with last = 1, tx_done 104 cycles after tx_dv -> exactly one tx_dv pulse with tx_byte = 8'h41, grant 01 then 00, busy low afterwards.
REQ-030 Simultaneous requests after reset: req0 sends 8'hAA (last = 1) and req1 sends 8'h55 (last = 1) -> tx order AA then 55, and req1_ready stays low until AA's tx_done.
REQ-031 Burst lock: req1 sends 8'h31, 8'h32, 8'h33 with last only on 8'h33, while req0 stays valid -> all three bytes go out before any req0 byte.
REQ-032 Timeout with TIMEOUT = 16: tx_done is never returned -> timeout_err pulses at cycle 16 of WAIT_DONE, grant goes to 00, and the other requester is served next.
REQ-033 Reset mid-operation: hwrst_n is pulled low during WAIT_DONE, then released -> all outputs hold their reset values, there is no spurious tx_dv, and req0 has priority.
REQ-034 A stray tx_done pulse in IDLE or ACCEPT -> no state change and no ready or grant change.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, burst-locking arbiter that shares one uart_tx between two requesters.
// Rev 1.0
`default_nettype none

module uart_tx_arbiter #(
  parameter int TIMEOUT = 2048
) (
  input  logic       hwclk,
  input  logic       hwrst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_byte,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_byte,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_err
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCEPT    = 2'd1,
    FIRE      = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     rst_sync_q;
  logic [1:0]     grant_q, grant_d;
  logic           prio_q, prio_d;
  logic [7:0]     byte_q, byte_d;
  logic           last_q, last_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           pick0;
  logic           handshake;
  logic           wdog_hit;

  // Release is synchronised; assertion stays asynchronous through hwrst_n.
  always_ff @(posedge hwclk or negedge hwrst_n) begin
    if (!hwrst_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  // prio_q = 1 means req1 is favoured.
  assign pick0     = prio_q ? !req1_valid : req0_valid;
  assign handshake = grant_q[1] ? req1_valid : req0_valid;
  assign wdog_hit  = (wdog_q == WDW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    prio_d      = prio_q;
    byte_d      = byte_q;
    last_d      = last_q;
    wdog_d      = '0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    tx_dv       = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d = pick0 ? 2'b01 : 2'b10;
          state_d = ACCEPT;
        end
      end
      ACCEPT: begin
        req0_ready = grant_q[0];
        req1_ready = grant_q[1];
        if (handshake) begin
          byte_d  = grant_q[1] ? req1_byte : req0_byte;
          last_d  = grant_q[1] ? req1_last : req0_last;
          state_d = FIRE;
        end
      end
      FIRE: begin
        tx_dv   = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        wdog_d = (wdog_q == WDW'(TIMEOUT)) ? wdog_q : wdog_q + WDW'(1);
        if (tx_done) begin
          if (last_q) begin
            grant_d = 2'b00;
            prio_d  = grant_q[0];
            state_d = IDLE;
          end else begin
            state_d = ACCEPT;
          end
        end else if (wdog_hit) begin
          timeout_err = 1'b1;
          grant_d     = 2'b00;
          prio_d      = grant_q[0];
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Until the release synchroniser fills, registers simply keep their reset values.
  always_ff @(posedge hwclk or negedge hwrst_n) begin
    if (!hwrst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      prio_q  <= 1'b0;
      byte_q  <= 8'h00;
      last_q  <= 1'b0;
      wdog_q  <= '0;
    end else if (rst_sync_q[1]) begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  assign tx_byte = byte_q;
  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);

endmodule

`default_nettype wire
